// File: rtl/mul_tree_feeder.sv
// Packs bf16 operand beats into 8-slot words for a multiplier tree, padding unused slots with ONE.
// Latency: the word is issued on the edge after the group completes, then mul_stb is high for one cycle.
// Backpressure: in_ready drops while a completed group waits on issue_ready or on a mode-change drain.
module mul_tree_feeder #(
   parameter int          DRAIN = 12,
   parameter logic [15:0] ONE   = 16'h3F80
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [15:0]  in_data,
   input  logic         in_valid,
   input  logic         in_last,
   output logic         in_ready,
   input  logic [1:0]   mode_in,
   input  logic         issue_ready,
   output logic [127:0] mul_ins,
   output logic         mul_stb,
   output logic [1:0]   mode,
   output logic         busy,
   output logic [15:0]  issue_cnt
);

   localparam int DW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         asm_cnt_q, asm_cnt_d;
   logic [1:0]         asm_mode_q, asm_mode_d;
   logic [7:0][15:0]   asm_buf_q, asm_buf_d;
   logic [DW-1:0]      drain_cnt_q, drain_cnt_d;
   logic [127:0]       mul_ins_q, mul_ins_d;
   logic [1:0]         mode_q, mode_d;
   logic               mul_stb_q, mul_stb_d;
   logic [15:0]        issue_cnt_q, issue_cnt_d;

   logic               asm_done;
   logic               drain_ok;
   logic               accept;
   logic               issue;
   logic [1:0]         beat_mode;
   logic [2:0]         slot;
   logic               beat_closes;

   assign asm_done  = (state_q == DONE);
   assign in_ready  = !asm_done;
   assign drain_ok  = (asm_mode_q == mode_q) || (drain_cnt_q == '0);
   assign accept    = in_valid && in_ready;
   assign issue     = asm_done && issue_ready && drain_ok;
   assign busy      = (state_q != IDLE) || (drain_cnt_q != '0);
   assign mul_ins   = mul_ins_q;
   assign mul_stb   = mul_stb_q;
   assign mode      = mode_q;
   assign issue_cnt = issue_cnt_q;

   // Next-state: assembly of beats into slots, issue of completed groups, drain countdown.
   always_comb begin
      state_d     = state_q;
      asm_cnt_d   = asm_cnt_q;
      asm_mode_d  = asm_mode_q;
      asm_buf_d   = asm_buf_q;
      drain_cnt_d = drain_cnt_q;
      mul_ins_d   = mul_ins_q;
      mode_d      = mode_q;
      mul_stb_d   = 1'b0;
      issue_cnt_d = issue_cnt_q;
      // mode of the beat being accepted: latched only on the first beat of a group
      beat_mode   = (state_q == IDLE) ? mode_in : asm_mode_q;
      // mode 1 skips slot 3, so beats 3..5 land one slot higher
      slot        = ((beat_mode == 2'd1) && (asm_cnt_q >= 3'd3)) ? asm_cnt_q + 3'd1 : asm_cnt_q;
      beat_closes = in_last || (asm_cnt_q == ((beat_mode == 2'd1) ? 3'd5 : 3'd7));

      if (issue) begin
         mul_ins_d   = asm_buf_q;
         mode_d      = asm_mode_q;
         mul_stb_d   = 1'b1;
         issue_cnt_d = issue_cnt_q + 16'd1;
         drain_cnt_d = DRAIN[DW-1:0];
         asm_buf_d   = {8{ONE}};
         asm_cnt_d   = 3'd0;
         state_d     = IDLE;
      end else if (drain_cnt_q != '0) begin
         drain_cnt_d = drain_cnt_q - DW'(1);
      end

      // accept and issue are exclusive: accept needs DONE to be clear, issue needs it set
      if (accept) begin
         asm_mode_d      = beat_mode;
         asm_buf_d[slot] = in_data;
         if (beat_closes) begin
            state_d = DONE;
         end else begin
            state_d   = FILL;
            asm_cnt_d = asm_cnt_q + 3'd1;
         end
      end
   end

   // State registers with asynchronous active-low reset; the buffer idles at all-ONE padding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         asm_cnt_q   <= 3'd0;
         asm_mode_q  <= 2'd0;
         asm_buf_q   <= {8{ONE}};
         drain_cnt_q <= '0;
         mul_ins_q   <= 128'd0;
         mode_q      <= 2'd0;
         mul_stb_q   <= 1'b0;
         issue_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         asm_cnt_q   <= asm_cnt_d;
         asm_mode_q  <= asm_mode_d;
         asm_buf_q   <= asm_buf_d;
         drain_cnt_q <= drain_cnt_d;
         mul_ins_q   <= mul_ins_d;
         mode_q      <= mode_d;
         mul_stb_q   <= mul_stb_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

endmodule
